// File: rtl/jump_pkg.sv
// Shared kind encodings and FSM state type for the jump resolve unit.
package jump_pkg;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT    = 2'b01,
        S_RESOLVE = 2'b10,
        S_WB      = 2'b11
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; stops at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/jump_resolve_unit.sv
// Resolves jump FU results: redirect pulse to IF, link writeback, misalign flag, stats.
module jump_resolve_unit
    import jump_pkg::*;
#(
    parameter int unsigned FU_LAT = 1,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [1:0]       issue_kind,
    input  logic [4:0]       issue_rd,
    input  logic [XLEN-1:0]  fu_pc_jump,
    input  logic [XLEN-1:0]  fu_pc_wb,
    input  logic             fu_cmp_res,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned LAT_W = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [1:0]        kind_q, kind_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc_jump_q, pc_jump_d;
    logic [XLEN-1:0]   pc_wb_q, pc_wb_d;
    logic              cmp_q, cmp_d;
    logic              issue_ready_q, issue_ready_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;
    logic              inc_br_c, inc_tk_c;
    logic              is_jump_c, taken_c;
    logic [XLEN-1:0]   target_c;

    // Decode of the captured instruction; JALR clears bit 0 of its target.
    always_comb begin
        is_jump_c = (kind_q == KIND_JAL) || (kind_q == KIND_JALR);
        taken_c   = is_jump_c || cmp_q;
        target_c  = (kind_q == KIND_JALR) ? {pc_jump_q[XLEN-1:1], 1'b0} : pc_jump_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        lat_cnt_d        = lat_cnt_q;
        kind_d           = kind_q;
        rd_d             = rd_q;
        pc_jump_d        = pc_jump_q;
        pc_wb_d          = pc_wb_q;
        cmp_d            = cmp_q;
        issue_ready_d    = issue_ready_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        wb_valid_d       = wb_valid_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        misalign_d       = 1'b0;
        inc_br_c         = 1'b0;
        inc_tk_c         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue_valid && issue_ready_q) begin
                    kind_d        = issue_kind;
                    rd_d          = issue_rd;
                    lat_cnt_d     = LAT_W'(FU_LAT - 1);
                    issue_ready_d = 1'b0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) begin
                    pc_jump_d = fu_pc_jump;
                    pc_wb_d   = fu_pc_wb;
                    cmp_d     = fu_cmp_res;
                    state_d   = S_RESOLVE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_RESOLVE: begin
                if (!is_jump_c) begin
                    inc_br_c = 1'b1;
                    inc_tk_c = cmp_q;
                end
                if (taken_c && target_c[1]) begin
                    misalign_d    = 1'b1;
                    issue_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    if (taken_c) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target_c;
                    end
                    if (is_jump_c && (rd_q != 5'd0)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = pc_wb_q;
                        state_d    = S_WB;
                    end else begin
                        issue_ready_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    wb_valid_d    = 1'b0;
                    issue_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                issue_ready_d = 1'b1;
                state_d       = S_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            lat_cnt_q        <= '0;
            kind_q           <= KIND_BR;
            rd_q             <= '0;
            pc_jump_q        <= '0;
            pc_wb_q          <= '0;
            cmp_q            <= 1'b0;
            issue_ready_q    <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            lat_cnt_q        <= lat_cnt_d;
            kind_q           <= kind_d;
            rd_q             <= rd_d;
            pc_jump_q        <= pc_jump_d;
            pc_wb_q          <= pc_wb_d;
            cmp_q            <= cmp_d;
            issue_ready_q    <= issue_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            wb_valid_q       <= wb_valid_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            misalign_q       <= misalign_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_br_c),
        .cnt   (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_tk_c),
        .cnt   (taken_cnt)
    );

    assign issue_ready    = issue_ready_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign misalign_exc   = misalign_q;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Directed bench for jump_resolve_unit (CNT_W=2 so saturation is reachable).
module tb_jump_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_kind;
    logic [4:0]       issue_rd;
    logic [XLEN-1:0]  fu_pc_jump;
    logic [XLEN-1:0]  fu_pc_wb;
    logic             fu_cmp_res;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             misalign_exc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jump_resolve_unit #(.FU_LAT(1), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_kind     (issue_kind),
        .issue_rd       (issue_rd),
        .fu_pc_jump     (fu_pc_jump),
        .fu_pc_wb       (fu_pc_wb),
        .fu_cmp_res     (fu_cmp_res),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .misalign_exc   (misalign_exc),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // FU outputs are junk except in the single cycle they are valid.
    task automatic fu_junk(input logic cmp);
        fu_pc_jump = 32'hDEAD_BEE0;
        fu_pc_wb   = 32'hCAFE_F00C;
        fu_cmp_res = ~cmp;
    endtask

    // Issue one op and present FU results one cycle later; returns in the RESOLVE cycle's successor.
    task automatic do_issue(input logic [1:0] kind, input logic [4:0] rd,
                            input logic [31:0] pj, input logic [31:0] pw, input logic cmp);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_kind  = kind;
        issue_rd    = rd;
        fu_junk(cmp);
        @(negedge clk);
        issue_valid = 1'b0;
        issue_kind  = 2'b00;
        issue_rd    = 5'd0;
        fu_pc_jump  = pj;
        fu_pc_wb    = pw;
        fu_cmp_res  = cmp;
        check("ready_low_wait", 32'(issue_ready), 32'd0);
        @(negedge clk);
        fu_junk(cmp);
        check("ready_low_resolve", 32'(issue_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_kind  = 2'b00;
        issue_rd    = 5'd0;
        wb_ready    = 1'b0;
        fu_junk(1'b0);
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(issue_ready), 32'd1);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_misalign", 32'(misalign_exc), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_br_cnt", 32'(branch_cnt), 32'd0);
        rst_n = 1'b1;

        // 1: BEQ not taken
        do_issue(2'b00, 5'd1, 32'h0000_0200, 32'h0000_0010, 1'b0);
        check("t1_ready_back", 32'(issue_ready), 32'd1);
        check("t1_redirect", 32'(redirect_valid), 32'd0);
        check("t1_wb", 32'(wb_valid), 32'd0);
        check("t1_br_cnt", 32'(branch_cnt), 32'd1);
        check("t1_tk_cnt", 32'(taken_cnt), 32'd0);

        // 2: BNE taken
        do_issue(2'b00, 5'd2, 32'h0000_0100, 32'h0000_0020, 1'b1);
        check("t2_redirect", 32'(redirect_valid), 32'd1);
        check("t2_redirect_pc", redirect_pc, 32'h0000_0100);
        check("t2_tk_cnt", 32'(taken_cnt), 32'd1);
        check("t2_br_cnt", 32'(branch_cnt), 32'd2);
        check("t2_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("t2_redirect_pulse", 32'(redirect_valid), 32'd0);

        // 3: JALR with stalled writeback
        wb_ready = 1'b0;
        do_issue(2'b10, 5'd5, 32'h0000_2001, 32'h0000_0044, 1'b0);
        check("t3_redirect", 32'(redirect_valid), 32'd1);
        check("t3_redirect_pc", redirect_pc, 32'h0000_2000);
        check("t3_wb_rd", 32'(wb_rd), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check("t3_wb_valid_held", 32'(wb_valid), 32'd1);
            check("t3_wb_data", wb_data, 32'h0000_0044);
            check("t3_ready_busy", 32'(issue_ready), 32'd0);
            if (i == 1) check("t3_redirect_pulse", 32'(redirect_valid), 32'd0);
            if (i == 3) wb_ready = 1'b1;
            @(negedge clk);
        end
        wb_ready = 1'b0;
        check("t3_wb_done", 32'(wb_valid), 32'd0);
        check("t3_ready_back", 32'(issue_ready), 32'd1);
        check("t3_br_cnt", 32'(branch_cnt), 32'd2);

        // 4: JAL rd=0 to misaligned target
        do_issue(2'b01, 5'd0, 32'h0000_0102, 32'h0000_0050, 1'b0);
        check("t4_misalign", 32'(misalign_exc), 32'd1);
        check("t4_redirect", 32'(redirect_valid), 32'd0);
        check("t4_wb", 32'(wb_valid), 32'd0);
        check("t4_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        check("t4_misalign_pulse", 32'(misalign_exc), 32'd0);

        // 5: counters at br=2 tk=1; four taken branches saturate at 3
        check("t5_tk_cnt_0", 32'(taken_cnt), 32'd1);
        check("t5_tk_cnt_1", 32'(taken_cnt), 32'd1);
        do_issue(2'b11, 5'd0, 32'h0000_0300, 32'h0, 1'b1);
        check("t5_tk_cnt_a", 32'(taken_cnt), 32'd2);
        check("t5_br_cnt_a", 32'(branch_cnt), 32'd3);
        do_issue(2'b00, 5'd0, 32'h0000_0304, 32'h0, 1'b1);
        check("t5_tk_cnt_b", 32'(taken_cnt), 32'd3);
        check("t5_br_cnt_b", 32'(branch_cnt), 32'd3);
        do_issue(2'b00, 5'd0, 32'h0000_0308, 32'h0, 1'b1);
        check("t5_tk_cnt_c", 32'(taken_cnt), 32'd3);
        do_issue(2'b00, 5'd0, 32'h0000_030C, 32'h0, 1'b1);
        check("t5_tk_cnt_d", 32'(taken_cnt), 32'd3);
        check("t5_br_cnt_d", 32'(branch_cnt), 32'd3);
        check("t5_redirect_pc", redirect_pc, 32'h0000_030C);

        // 6a: reset during WB
        do_issue(2'b01, 5'd7, 32'h0000_0400, 32'h0000_0060, 1'b0);
        check("t6_wb_valid", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wb", 32'(wb_valid), 32'd0);
        check("t6_rst_redirect", 32'(redirect_valid), 32'd0);
        check("t6_rst_ready", 32'(issue_ready), 32'd1);
        check("t6_rst_tk_cnt", 32'(taken_cnt), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_wb_after", 32'(wb_valid), 32'd0);
            check("t6_no_redir_after", 32'(redirect_valid), 32'd0);
        end

        // 6b: reset during WAIT
        @(negedge clk);
        issue_valid = 1'b1;
        issue_kind  = 2'b00;
        fu_junk(1'b1);
        @(negedge clk);
        issue_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("t6_wait_rst_ready", 32'(issue_ready), 32'd1);
        fu_pc_jump = 32'h0000_0500;
        fu_cmp_res = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        fu_junk(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_wait_no_redir", 32'(redirect_valid), 32'd0);
            check("t6_wait_br_cnt", 32'(branch_cnt), 32'd0);
        end

        // 6c: issue while busy is ignored
        @(negedge clk);
        issue_valid = 1'b1;
        issue_kind  = 2'b01;
        issue_rd    = 5'd3;
        fu_junk(1'b0);
        @(negedge clk);
        issue_kind  = 2'b00;
        issue_rd    = 5'd9;
        fu_pc_jump  = 32'h0000_0600;
        fu_pc_wb    = 32'h0000_0070;
        fu_cmp_res  = 1'b1;
        @(negedge clk);
        fu_junk(1'b1);
        @(negedge clk);
        issue_valid = 1'b0;
        check("t6c_redirect", 32'(redirect_valid), 32'd1);
        check("t6c_redirect_pc", redirect_pc, 32'h0000_0600);
        check("t6c_wb_rd", 32'(wb_rd), 32'd3);
        check("t6c_wb_data", wb_data, 32'h0000_0070);
        @(negedge clk);
        check("t6c_wb_done", 32'(wb_valid), 32'd0);
        check("t6c_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        check("t6c_no_second", 32'(redirect_valid), 32'd0);
        check("t6c_br_cnt", 32'(branch_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
